// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared constants and FSM state type for the BNN image loader
package bnn_pkg;
    localparam int IMG_BITS = 904;
    localparam int PAD_BITS = 4;
    localparam int NUM_BYTES = 113;
    localparam int RESULT_W = 4;
    localparam logic [RESULT_W-1:0] RESULT_TIMEOUT = 4'hF;

    typedef enum logic [1:0] {FILL, RUN, DELIVER, CLEAR} loader_state_t;
endpackage

// File: rtl/img_byte_packer.sv
// rtl/img_byte_packer.sv - MSB-first byte packer building the BNN image word
module img_byte_packer #(
    parameter int IMG_BITS  = 904,
    parameter int BYTE_W    = 8,
    parameter int PAD_BITS  = 4,
    parameter int NUM_BYTES = (IMG_BITS + BYTE_W - 1) / BYTE_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr,
    input  logic [BYTE_W-1:0]   byte_data,
    input  logic                abort,
    input  logic                clr,
    output logic [IMG_BITS-1:0] img,
    output logic                last
);
    localparam int CNT_W = $clog2(NUM_BYTES);
    localparam logic [BYTE_W-1:0] PAD_MASK = BYTE_W'((1 << PAD_BITS) - 1);

    logic [CNT_W-1:0]  byte_cnt;
    logic [BYTE_W-1:0] wr_data;

    assign last    = wr && !abort && (byte_cnt == CNT_W'(NUM_BYTES - 1));
    // The final byte carries the padding LSBs, which the BNN expects as zeros.
    assign wr_data = last ? (byte_data & ~PAD_MASK) : byte_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            img      <= '0;
        end else if (abort || clr) begin
            byte_cnt <= '0;
        end else if (wr) begin
            img[IMG_BITS - 1 - BYTE_W * int'(byte_cnt) -: BYTE_W] <= wr_data;
            byte_cnt <= last ? '0 : byte_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/bnn_img_loader.sv
// rtl/bnn_img_loader.sv - host-side BNN loader: fill image, run, deliver digit, clear
module bnn_img_loader #(
    parameter int IMG_BITS       = 904,
    parameter int BYTE_W         = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BYTE_W-1:0]   rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    input  logic                frame_abort,
    output logic [IMG_BITS-1:0] img_out,
    output logic                img_buffer_full,
    output logic                bnn_enable,
    output logic                bnn_clear,
    input  logic                result_ready,
    input  logic [3:0]          result_in,
    output logic                result_valid,
    output logic [3:0]          result_digit,
    input  logic                result_ack,
    output logic                rx_overrun,
    output logic                timeout_err
);
    import bnn_pkg::*;

    loader_state_t state;
    logic pk_wr;
    logic pk_abort;
    logic pk_clr;
    logic pk_last;

    assign rx_ready = (state == FILL);
    assign pk_wr    = rx_valid && rx_ready;
    assign pk_abort = frame_abort && rx_ready;
    assign pk_clr   = (state == CLEAR) && !result_ready;

    img_byte_packer #(
        .IMG_BITS (IMG_BITS),
        .BYTE_W   (BYTE_W),
        .PAD_BITS (PAD_BITS)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr        (pk_wr),
        .byte_data (rx_data),
        .abort     (pk_abort),
        .clr       (pk_clr),
        .img       (img_out),
        .last      (pk_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_overrun <= 1'b0;
        end else if (rx_valid && !rx_ready) begin
            rx_overrun <= 1'b1;
        end
    end

`ifdef BNN_TIMEOUT_EN
    logic [15:0] timeout_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= FILL;
            img_buffer_full <= 1'b0;
            bnn_enable      <= 1'b0;
            bnn_clear       <= 1'b0;
            result_valid    <= 1'b0;
            result_digit    <= '0;
`ifdef BNN_TIMEOUT_EN
            timeout_cnt     <= '0;
            timeout_err     <= 1'b0;
`endif
        end else begin
            case (state)
                FILL: begin
                    if (pk_last) begin
                        state           <= RUN;
                        img_buffer_full <= 1'b1;
                        bnn_enable      <= 1'b1;
`ifdef BNN_TIMEOUT_EN
                        timeout_cnt     <= '0;
`endif
                    end
                end
                RUN: begin
                    if (result_ready) begin
                        result_digit <= result_in;
                        result_valid <= 1'b1;
                        bnn_enable   <= 1'b0;
                        state        <= DELIVER;
                    end
`ifdef BNN_TIMEOUT_EN
                    else if (timeout_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                        bnn_enable      <= 1'b0;
                        img_buffer_full <= 1'b0;
                        result_digit    <= RESULT_TIMEOUT;
                        result_valid    <= 1'b1;
                        timeout_err     <= 1'b1;
                        state           <= DELIVER;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
`endif
                end
                DELIVER: begin
                    if (result_ack) begin
                        result_valid <= 1'b0;
                        bnn_clear    <= 1'b1;
                        state        <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (!result_ready) begin
                        bnn_clear       <= 1'b0;
                        img_buffer_full <= 1'b0;
                        state           <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_bnn_img_loader.sv
// tb/tb_bnn_img_loader.sv - self-checking bench for bnn_img_loader
module tb_bnn_img_loader;
    localparam int N = 113;
`ifdef BNN_TIMEOUT_EN
    localparam int TB_TIMEOUT = 100;
`else
    localparam int TB_TIMEOUT = 65535;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   rx_data = '0;
    logic         rx_valid = 1'b0;
    logic         rx_ready;
    logic         frame_abort = 1'b0;
    logic [903:0] img_out;
    logic         img_buffer_full;
    logic         bnn_enable;
    logic         bnn_clear;
    logic         result_ready = 1'b0;
    logic [3:0]   result_in = '0;
    logic         result_valid;
    logic [3:0]   result_digit;
    logic         result_ack = 1'b0;
    logic         rx_overrun;
    logic         timeout_err;

    int vectors = 0;
    int errors = 0;
    logic [7:0]   mem [N];
    logic [903:0] exp_img;

    always #5 clk = ~clk;

    bnn_img_loader #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_abort(frame_abort), .img_out(img_out),
        .img_buffer_full(img_buffer_full), .bnn_enable(bnn_enable),
        .bnn_clear(bnn_clear), .result_ready(result_ready), .result_in(result_in),
        .result_valid(result_valid), .result_digit(result_digit),
        .result_ack(result_ack), .rx_overrun(rx_overrun), .timeout_err(timeout_err)
    );

    // Image = the accepted bytes concatenated in arrival order, first byte on top.
    function automatic logic [903:0] model_img();
        logic [903:0] acc;
        acc = '0;
        for (int k = 0; k < N; k++) acc = (acc << 8) | {896'b0, mem[k]};
        return acc;
    endfunction

    task automatic model_write(input int k, input logic [7:0] b);
        mem[k] = (k == N - 1) ? (b & 8'hF0) : b;
    endtask

    task automatic send_frame(input bit rnd, input logic [7:0] val, input bit gaps);
        logic [7:0] b;
        for (int k = 0; k < N; k++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                for (int i = 0; i < g; i++) begin
                    @(negedge clk);
                    rx_valid = 1'b0;
                end
            end
            @(negedge clk);
            if (k == N - 1) begin
                vectors++;
                if (img_buffer_full !== 1'b0) begin
                    errors++; $display("FAIL ibf_early got %b exp 0", img_buffer_full);
                end
            end
            b = rnd ? 8'($urandom) : val;
            rx_valid = 1'b1;
            rx_data = b;
            model_write(k, b);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        exp_img = model_img();
        vectors++;
        if (img_out !== exp_img) begin
            errors++; $display("FAIL img got %h exp %h", img_out, exp_img);
        end
        vectors++;
        if ({img_buffer_full, bnn_enable, rx_ready, result_valid} !== 4'b1100) begin
            errors++;
            $display("FAIL run_entry got %b exp 1100", {img_buffer_full, bnn_enable, rx_ready, result_valid});
        end
    endtask

    task automatic finish_inference(input logic [3:0] digit, input int delay, input int ack_delay);
        int hold;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            vectors++;
            if ({bnn_enable, result_valid} !== 2'b10) begin
                errors++; $display("FAIL run_hold got %b exp 10", {bnn_enable, result_valid});
            end
        end
        @(negedge clk);
        result_ready = 1'b1;
        result_in = digit;
        @(negedge clk);
        vectors++;
        if ({result_valid, result_digit, bnn_enable, img_buffer_full} !== {1'b1, digit, 2'b01}) begin
            errors++;
            $display("FAIL deliver got %b_%h_%b_%b exp 1_%h_0_1", result_valid, result_digit,
                     bnn_enable, img_buffer_full, digit);
        end
        for (int i = 0; i < ack_delay; i++) begin
            @(negedge clk);
            vectors++;
            if ({result_valid, result_digit} !== {1'b1, digit}) begin
                errors++; $display("FAIL deliver_hold got %b_%h exp 1_%h", result_valid, result_digit, digit);
            end
        end
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        vectors++;
        if ({result_valid, bnn_clear, img_out === exp_img} !== 3'b011) begin
            errors++;
            $display("FAIL ack got valid=%b clear=%b img_ok=%b exp 0 1 1", result_valid, bnn_clear, img_out === exp_img);
        end
        hold = $urandom_range(0, 3);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            vectors++;
            if ({bnn_clear, rx_ready} !== 2'b10) begin
                errors++; $display("FAIL clear_hold got %b exp 10", {bnn_clear, rx_ready});
            end
        end
        result_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bnn_clear, img_buffer_full, rx_ready} !== 3'b001) begin
            errors++; $display("FAIL clear_exit got %b exp 001", {bnn_clear, img_buffer_full, rx_ready});
        end
        vectors++;
        if (img_out !== exp_img) begin
            errors++; $display("FAIL img_stable got %h exp %h", img_out, exp_img);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) mem[k] = 8'h00;
        repeat (2) @(negedge clk);
        vectors++;
        if (img_out !== 904'b0) begin
            errors++; $display("FAIL reset_img got %h exp 0", img_out);
        end
        vectors++;
        if ({rx_ready, img_buffer_full, bnn_enable, bnn_clear, result_valid, result_digit, rx_overrun, timeout_err}
            !== 11'b1_0000_0000_00) begin
            errors++;
            $display("FAIL reset_out got %b exp 10000000000",
                     {rx_ready, img_buffer_full, bnn_enable, bnn_clear, result_valid, result_digit, rx_overrun, timeout_err});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_full_ff();
        send_frame(1'b0, 8'hFF, 1'b0);
        vectors++;
        if ({img_out[903:4], img_out[3:0]} !== {{900{1'b1}}, 4'h0}) begin
            errors++; $display("FAIL ff_pattern got %h", img_out);
        end
        finish_inference(4'd7, 50, 20);
    endtask

    task automatic test_overrun();
        vectors++;
        if (rx_overrun !== 1'b0) begin
            errors++; $display("FAIL overrun_init got %b exp 0", rx_overrun);
        end
        send_frame(1'b1, 8'h00, 1'b0);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data = 8'($urandom);
        @(negedge clk);
        rx_valid = 1'b0;
        vectors++;
        if ({rx_overrun, bnn_enable, img_out === exp_img} !== 3'b111) begin
            errors++;
            $display("FAIL overrun got ovr=%b en=%b img_ok=%b exp 1 1 1", rx_overrun, bnn_enable, img_out === exp_img);
        end
        finish_inference(4'($urandom_range(0, 9)), 3, 2);
        vectors++;
        if (rx_overrun !== 1'b1) begin
            errors++; $display("FAIL overrun_sticky got %b exp 1", rx_overrun);
        end
    endtask

    task automatic test_abort();
        logic [7:0] b;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            b = 8'($urandom);
            rx_valid = 1'b1;
            rx_data = b;
            model_write(k, b);
        end
        @(negedge clk);
        rx_data = 8'($urandom);
        frame_abort = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        frame_abort = 1'b0;
        exp_img = model_img();
        vectors++;
        if ({rx_ready, img_out === exp_img} !== 2'b11) begin
            errors++; $display("FAIL abort got rdy=%b img_ok=%b exp 1 1", rx_ready, img_out === exp_img);
        end
        result_ready = 1'b1;
        result_in = 4'd3;
        repeat (3) @(negedge clk);
        result_ready = 1'b0;
        vectors++;
        if ({result_valid, bnn_enable, rx_ready} !== 3'b001) begin
            errors++; $display("FAIL ready_in_fill got %b exp 001", {result_valid, bnn_enable, rx_ready});
        end
        send_frame(1'b0, 8'hA5, 1'b0);
        finish_inference(4'd2, 5, 1);
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 4; f++) begin
            send_frame(1'b1, 8'h00, 1'b1);
            finish_inference(4'($urandom_range(0, 14)), $urandom_range(0, 10), $urandom_range(0, 5));
        end
    endtask

    task automatic test_reset_mid();
        send_frame(1'b1, 8'h00, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < N; k++) mem[k] = 8'h00;
        vectors++;
        if ({img_out === 904'b0, rx_ready, img_buffer_full, bnn_enable, rx_overrun} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_mid got img0=%b rdy=%b ibf=%b en=%b ovr=%b exp 1 1 0 0 0",
                     img_out === 904'b0, rx_ready, img_buffer_full, bnn_enable, rx_overrun);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(1'b1, 8'h00, 1'b0);
        finish_inference(4'd9, 2, 0);
    endtask

`ifdef BNN_TIMEOUT_EN
    task automatic test_timeout();
        send_frame(1'b1, 8'h00, 1'b0);
        for (int c = 1; c < 100; c++) begin
            @(negedge clk);
            vectors++;
            if (result_valid !== 1'b0) begin
                errors++; $display("FAIL timeout_early got %b exp 0 at %0d", result_valid, c);
            end
        end
        @(negedge clk);
        vectors++;
        if ({result_valid, result_digit, timeout_err, bnn_enable, img_buffer_full} !== 8'b1_1111_1_00) begin
            errors++;
            $display("FAIL timeout got %b_%h_%b_%b_%b exp 1_f_1_0_0", result_valid, result_digit,
                     timeout_err, bnn_enable, img_buffer_full);
        end
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        @(negedge clk);
        vectors++;
        if ({rx_ready, bnn_clear, timeout_err} !== 3'b101) begin
            errors++; $display("FAIL timeout_exit got %b exp 101", {rx_ready, bnn_clear, timeout_err});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_ff();
        test_overrun();
        test_abort();
        test_random_frames();
        test_reset_mid();
`ifdef BNN_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
